dcm_rf_sched: RTL and testbench

//  Shares the single-port 128x8 register file between the SPI host port and the per-channel motor update engine.

---
 rtl/dcm_rf_sched.sv | 189 ++++++++++++++++++
 tb/tb_dcm_rf_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_rf_sched.sv
// dcm_rf_sched: shares the single-port 128x8 register file between the SPI host and the channel
// engine, and scans the engine round-robin over NCHAN channels. Define DCM_RF_PROT_EN for write protection.
module dcm_rf_sched #(
    parameter int NCHAN      = 8,
    parameter int STARVE_MAX = 4,
    parameter int SCAN_GAP   = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     spi_req,
    input  logic                     spi_we,
    input  logic [6:0]               spi_addr,
    input  logic [7:0]               spi_wdata,
    output logic                     spi_ack,
    output logic [7:0]               spi_rdata,
    input  logic                     eng_req,
    input  logic                     eng_we,
    input  logic [6:0]               eng_addr,
    input  logic [7:0]               eng_wdata,
    output logic                     eng_ack,
    output logic [7:0]               eng_rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [6:0]               ram_addr,
    output logic [7:0]               ram_wdata,
    input  logic [7:0]               ram_rdata,
    input  logic                     scan_en,
    output logic                     eng_start,
    output logic [$clog2(NCHAN)-1:0] eng_chan,
    input  logic                     eng_done,
`ifdef DCM_RF_PROT_EN
    output logic                     prot_err,
`endif
    output logic                     scan_wrap
);

    localparam int CW = $clog2(NCHAN);
    localparam int GW = $clog2(SCAN_GAP + 1) + 1;

    localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [GW-1:0] GAP_LIM    = GW'(SCAN_GAP);
    localparam logic [CW-1:0] LAST_CHAN  = CW'(NCHAN - 1);

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_RESP  = 2'd2;

    localparam logic [1:0] SC_IDLE  = 2'd0;
    localparam logic [1:0] SC_START = 2'd1;
    localparam logic [1:0] SC_WAIT  = 2'd2;
    localparam logic [1:0] SC_GAP   = 2'd3;

    logic [1:0]    arb_state;
    logic          owner_eng;
    logic [3:0]    starve_cnt;
    logic          lat_we;
    logic [6:0]    lat_addr;
    logic [7:0]    lat_wdata;
    logic          lat_block;
    logic [7:0]    spi_hold;
    logic [7:0]    eng_hold;

    logic          any_req;
    logic          eng_wins;
    logic          grant_we;
    logic [6:0]    grant_addr;
    logic [7:0]    grant_wdata;
    logic          grant_block;
    logic          in_issue;
    logic          in_resp;

    logic [1:0]    sc_state;
    logic [GW-1:0] gap_cnt;

    always_comb begin
        any_req     = spi_req | eng_req;
        eng_wins    = eng_req & (~spi_req | (starve_cnt == STARVE_LIM));
        grant_we    = eng_wins ? eng_we    : spi_we;
        grant_addr  = eng_wins ? eng_addr  : spi_addr;
        grant_wdata = eng_wins ? eng_wdata : spi_wdata;
`ifdef DCM_RF_PROT_EN
        // Engine owns the lower half of the map, host owns the upper half.
        grant_block = grant_we & (eng_wins ? grant_addr[6] : ~grant_addr[6]);
`else
        grant_block = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            arb_state  <= ARB_IDLE;
            owner_eng  <= 1'b0;
            starve_cnt <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_block  <= 1'b0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    // A losing engine always implies a contested choice, since eng_wins covers !spi_req.
                    if (!eng_req || eng_wins)
                        starve_cnt <= '0;
                    else if (starve_cnt != STARVE_LIM)
                        starve_cnt <= starve_cnt + 4'd1;
                    if (any_req) begin
                        owner_eng <= eng_wins;
                        lat_we    <= grant_we;
                        lat_addr  <= grant_addr;
                        lat_wdata <= grant_wdata;
                        lat_block <= grant_block;
                        arb_state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: arb_state <= ARB_RESP;
                ARB_RESP:  arb_state <= ARB_IDLE;
                default:   arb_state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        in_issue  = (arb_state == ARB_ISSUE);
        in_resp   = (arb_state == ARB_RESP);
        ram_en    = in_issue & ~lat_block;
        ram_we    = ram_en & lat_we;
        ram_addr  = lat_addr;
        ram_wdata = lat_wdata;
        spi_ack   = in_resp & ~owner_eng;
        eng_ack   = in_resp & owner_eng;
        spi_rdata = spi_ack ? ram_rdata : spi_hold;
        eng_rdata = eng_ack ? ram_rdata : eng_hold;
    end

`ifdef DCM_RF_PROT_EN
    always_comb prot_err = in_resp & lat_block;
`endif

    // Read data is passed straight through in the ack cycle and held afterwards.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            spi_hold <= '0;
            eng_hold <= '0;
        end else begin
            if (spi_ack) spi_hold <= ram_rdata;
            if (eng_ack) eng_hold <= ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sc_state  <= SC_IDLE;
            eng_chan  <= '0;
            gap_cnt   <= '0;
            scan_wrap <= 1'b0;
        end else begin
            scan_wrap <= 1'b0;
            case (sc_state)
                SC_IDLE: begin
                    if (scan_en) sc_state <= SC_START;
                end
                SC_START: sc_state <= SC_WAIT;
                SC_WAIT: begin
                    if (eng_done) begin
                        eng_chan  <= (eng_chan == LAST_CHAN) ? '0 : eng_chan + CW'(1);
                        scan_wrap <= (eng_chan == LAST_CHAN);
                        gap_cnt   <= '0;
                        sc_state  <= SC_GAP;
                    end
                end
                SC_GAP: begin
                    // SCAN_GAP counted clocks plus the deciding clock, so a zero gap still spends one clock here.
                    if (gap_cnt == GAP_LIM)
                        sc_state <= scan_en ? SC_START : SC_IDLE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                default: sc_state <= SC_IDLE;
            endcase
        end
    end

    always_comb eng_start = (sc_state == SC_START);

    a_one_owner: assert property (@(posedge clk) disable iff (!resetn) !(spi_ack && eng_ack));
    a_start_pulse: assert property (@(posedge clk) disable iff (!resetn) eng_start |=> !eng_start);
    a_chan_range: assert property (@(posedge clk) disable iff (!resetn) 32'(eng_chan) < NCHAN);

endmodule

// File: tb/tb_dcm_rf_sched.sv
// Self-checking bench for dcm_rf_sched: cycle-level reference model plus directed literal checks.
module tb_dcm_rf_sched;
    localparam int NCHAN      = 8;
    localparam int STARVE_MAX = 4;
    localparam int SCAN_GAP   = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       spi_req = 1'b0, spi_we = 1'b0;
    logic [6:0] spi_addr = '0;
    logic [7:0] spi_wdata = '0;
    logic       spi_ack;
    logic [7:0] spi_rdata;
    logic       eng_req = 1'b0, eng_we = 1'b0;
    logic [6:0] eng_addr = '0;
    logic [7:0] eng_wdata = '0;
    logic       eng_ack;
    logic [7:0] eng_rdata;
    logic       ram_en, ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       scan_en = 1'b0;
    logic       eng_start;
    logic [2:0] eng_chan;
    logic       eng_done = 1'b0;
    logic       scan_wrap;
`ifdef DCM_RF_PROT_EN
    logic       prot_err;
`endif

    always #5 clk = ~clk;

    dcm_rf_sched #(.NCHAN(NCHAN), .STARVE_MAX(STARVE_MAX), .SCAN_GAP(SCAN_GAP)) dut (
        .clk(clk), .resetn(resetn),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_ack(eng_ack), .eng_rdata(eng_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .scan_en(scan_en), .eng_start(eng_start), .eng_chan(eng_chan), .eng_done(eng_done),
`ifdef DCM_RF_PROT_EN
        .prot_err(prot_err),
`endif
        .scan_wrap(scan_wrap)
    );

    // Register RAM: read-first, data one clock after the strobe.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one access at a time, decided whenever the arbiter is free.
    int         free_at = 0, issue_at = -1, ack_at = -1, losses = 0;
    bit         x_eng = 1'b0, x_we = 1'b0, x_blk = 1'b0;
    logic [6:0] x_addr = '0;
    logic [7:0] x_wdata = '0, x_rdata = '0;
    logic [7:0] shadow [128];
    int         sc_phase = 0;  // 0 idle, 1 start due, 2 awaiting done, 3 gap
    int         start_at = -1, gap_end = -1, wrap_at = -1, chan_x = 0;

    always @(posedge clk) begin : model
        int n;
        bit e;
        n = cyc;
        if (!resetn) begin
            chk_on = 1'b1;
            free_at = n + 1; issue_at = -1; ack_at = -1; losses = 0;
            sc_phase = 0; start_at = -1; wrap_at = -1; chan_x = 0;
        end else begin
            if (n >= free_at) begin
                e = eng_req && (!spi_req || losses == STARVE_MAX);
                if (!eng_req || e) losses = 0;
                else if (losses < STARVE_MAX) losses = losses + 1;
                if (spi_req || eng_req) begin
                    x_eng   = e;
                    x_we    = e ? eng_we : spi_we;
                    x_addr  = e ? eng_addr : spi_addr;
                    x_wdata = e ? eng_wdata : spi_wdata;
`ifdef DCM_RF_PROT_EN
                    x_blk = x_we && (x_eng ? x_addr[6] : !x_addr[6]);
`else
                    x_blk = 1'b0;
`endif
                    x_rdata = shadow[x_addr];
                    if (x_we && !x_blk) shadow[x_addr] = x_wdata;
                    issue_at = n + 1; ack_at = n + 2; free_at = n + 3;
                end
            end
            case (sc_phase)
                0: if (scan_en) begin start_at = n + 1; sc_phase = 1; end
                1: sc_phase = 2;
                2: if (eng_done) begin
                       chan_x = (chan_x + 1) % NCHAN;
                       if (chan_x == 0) wrap_at = n + 1;
                       gap_end = n + 1 + SCAN_GAP;
                       sc_phase = 3;
                   end
                default: if (n == gap_end) begin
                       if (scan_en) begin start_at = n + 1; sc_phase = 1; end
                       else sc_phase = 0;
                   end
            endcase
        end
        cyc = n + 1;
    end

    always @(negedge clk) begin : compare
        bit en_x, ackc;
        if (chk_on) begin
            en_x = (cyc == issue_at) && !x_blk;
            ackc = (cyc == ack_at);
            check("ram_en", 32'(ram_en), 32'(en_x));
            check("ram_we", 32'(ram_we), 32'(en_x && x_we));
            if (en_x) check("ram_addr", 32'(ram_addr), 32'(x_addr));
            if (en_x && x_we) check("ram_wdata", 32'(ram_wdata), 32'(x_wdata));
            check("spi_ack", 32'(spi_ack), 32'(ackc && !x_eng));
            check("eng_ack", 32'(eng_ack), 32'(ackc && x_eng));
            if (ackc && !x_we && !x_eng) check("spi_rdata", 32'(spi_rdata), 32'(x_rdata));
            if (ackc && !x_we && x_eng) check("eng_rdata", 32'(eng_rdata), 32'(x_rdata));
`ifdef DCM_RF_PROT_EN
            check("prot_err", 32'(prot_err), 32'(ackc && x_blk));
`endif
            check("eng_start", 32'(eng_start), 32'(cyc == start_at));
            check("eng_chan", 32'(eng_chan), 32'(chan_x));
            check("scan_wrap", 32'(scan_wrap), 32'(cyc == wrap_at));
        end
    end

    // Engine responder: done a fixed 3 clocks after start, or random delay plus stray pulses.
    bit rnd_eng = 1'b0;
    bit armed = 1'b0;
    int due = 0;
    always @(negedge clk) begin
        if (eng_start) begin
            armed = 1'b1;
            due = cyc + (rnd_eng ? int'($urandom_range(1, 6)) : 3);
        end
    end
    always @(posedge clk) begin
        #1;
        if (!resetn) armed = 1'b0;
        eng_done = armed && (cyc == due);
        if (eng_done) armed = 1'b0;
        else if (!armed && rnd_eng && $urandom_range(0, 15) == 0) eng_done = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic we, input logic [6:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        spi_req = 1'b1; spi_we = we; spi_addr = a; spi_wdata = d;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (spi_ack) begin got = 1'b1; break; end
        end
        check("spi_ack_seen", 32'(got), 32'd1);
        tick();
        spi_req = 1'b0;
    endtask

    task automatic eng_xfer(input logic we, input logic [6:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        eng_req = 1'b1; eng_we = we; eng_addr = a; eng_wdata = d;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (eng_ack) begin got = 1'b1; break; end
        end
        check("eng_ack_seen", 32'(got), 32'd1);
        tick();
        eng_req = 1'b0;
    endtask

    // Both requesters held; bit i of pat is set when the i-th grant went to the engine.
    task automatic both_hold(input int n, output logic [31:0] pat, output int got);
        pat = '0;
        got = 0;
        spi_req = 1'b1; spi_we = 1'b0; spi_addr = 7'd70;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 7'd3;
        for (int k = 0; k < n * 3 + 20 && got < n; k++) begin
            @(negedge clk);
            if (eng_ack) begin pat[got] = 1'b1; got++; end
            else if (spi_ack) got++;
        end
        tick();
        spi_req = 1'b0;
        eng_req = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        mismatched++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0, en_at, ackl, got, n, wraps, starts, acks;
        logic [7:0] rd, saved;
        logic [31:0] pat;
        bit seen;
        int st [9];
        int ch [9];

        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'(i * 37 + 5);
            shadow[i] = 8'(i * 37 + 5);
        end
        mem[70] = 8'h64;
        shadow[70] = 8'h64;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_spi_ack", 32'(spi_ack), 32'd0);
        check("rst_eng_ack", 32'(eng_ack), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_scan_wrap", 32'(scan_wrap), 32'd0);
        check("rst_eng_chan", 32'(eng_chan), 32'd0);
        tick();
        resetn = 1'b1;

        // Lone SPI read of address 70.
        tick();
        spi_req = 1'b1; spi_we = 1'b0; spi_addr = 7'd70;
        t0 = cyc; en_at = -1; ackl = -1; rd = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram_en && en_at < 0) en_at = cyc;
            if (spi_ack) begin ackl = cyc; rd = spi_rdata; break; end
        end
        check("spi70_en_latency", 32'(en_at - t0), 32'd1);
        check("spi70_ack_latency", 32'(ackl - t0), 32'd2);
        check("spi70_rdata", 32'(rd), 32'h64);
        tick();
        spi_req = 1'b0;
        tick();

        // Continuous contention: S,S,S,S,E repeating.
        both_hold(15, pat, got);
        check("hold_count", 32'(got), 32'd15);
        check("hold_grants", pat, 32'h0000_4210);
        tick();

        // Two SPI wins, then reset in the issue cycle of an SPI write.
        spi_req = 1'b1; spi_we = 1'b0; spi_addr = 7'd70;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 7'd3;
        got = 0;
        for (int k = 0; k < 30 && got < 2; k++) begin
            @(negedge clk);
            if (spi_ack) got++;
        end
        tick();
        spi_we = 1'b1; spi_addr = 7'h20; spi_wdata = 8'hA5;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram_en && ram_we) begin seen = 1'b1; break; end
        end
        check("rst_write_issued", 32'(seen), 32'd1);
        resetn = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (spi_ack || eng_ack) acks++;
        end
        check("rst_dropped_ack", 32'(acks), 32'd0);
        tick();
        spi_req = 1'b0; eng_req = 1'b0; spi_we = 1'b0;
        resetn = 1'b1;
        both_hold(5, pat, got);
        check("rst_starve_cleared", pat, 32'h0000_0010);
        tick();

        // Scan: nine starts, spacing 3+1+SCAN_GAP+1, one wrap.
        scan_en = 1'b1;
        n = 0; wraps = 0;
        for (int k = 0; k < 400 && n < 9; k++) begin
            @(negedge clk);
            if (scan_wrap) wraps++;
            if (eng_start) begin st[n] = cyc; ch[n] = int'(eng_chan); n++; end
        end
        check("scan_starts", 32'(n), 32'd9);
        for (int i = 0; i < 9; i++) check("scan_chan_seq", 32'(ch[i]), 32'(i % NCHAN));
        for (int i = 0; i < 8; i++) check("scan_spacing", 32'(st[i+1] - st[i]), 32'(3 + 1 + SCAN_GAP + 1));
        check("scan_wraps", 32'(wraps), 32'd1);

        // Drop scan_en while channel 5 is being processed.
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (eng_start && eng_chan == 3'd5) begin seen = 1'b1; break; end
        end
        check("drop_chan5_started", 32'(seen), 32'd1);
        tick();
        scan_en = 1'b0;
        starts = 0;
        repeat (60) begin
            @(negedge clk);
            if (eng_start) starts++;
        end
        check("drop_no_start", 32'(starts), 32'd0);
        check("drop_chan_held", 32'(eng_chan), 32'd6);
        tick();

`ifdef DCM_RF_PROT_EN
        // Engine write into the host half is blocked but still acknowledged.
        saved = mem[7'h41];
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 7'h41; eng_wdata = 8'hFF;
        seen = 1'b0; got = 0; rd = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram_en) seen = 1'b1;
            if (eng_ack) begin got = 1; rd = {7'd0, prot_err}; break; end
        end
        check("prot_ack", 32'(got), 32'd1);
        check("prot_err_pulse", 32'(rd), 32'd1);
        check("prot_no_ram_en", 32'(seen), 32'd0);
        tick();
        eng_req = 1'b0;
        tick();
        check("prot_ram_kept", 32'(mem[7'h41]), 32'(saved));
        check("prot_ram_literal", 32'(mem[7'h41]), 32'h6A);
`else
        saved = '0;
`endif

        // Randomised traffic on both ports with random scanning alongside.
        rnd_eng = 1'b1;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    spi_xfer(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    eng_xfer(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(10, 60)) tick();
                    scan_en = ~scan_en;
                end
            end
        join
        scan_en = 1'b0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
